conv2_adder_tree_sequencer: RTL and testbench

Sequences the five gated adder stages of the convolution layer 2 accumulation tree. It owns the per-stage operand-gating enables and the per-stage supply-gating enables, so each stage toggles only in the cycles where it holds real data. It accepts one convolution window per cycle from the multiplier array, counts windows to the end of the output frame, drains the tree, and reports frame completion. It sits between the layer 2 control FSM (start/done) and the `adderStage*_2_gated` instances.

---
 rtl/conv2_seq_pkg.sv | 21 ++
 rtl/conv2_adder_tree_sequencer_gate_valid_pipe.sv | 40 ++++
 rtl/conv2_adder_tree_sequencer.sv | 136 +++++++++++++
 tb/tb_conv2_adder_tree_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_seq_pkg.sv
// Shared types and constants for the conv layer 2 adder-tree sequencer.
package conv2_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAKE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam int unsigned C_NUM_STAGES    = 5;
  localparam int unsigned C_OUT_DIM       = 22;
  localparam int unsigned C_TOTAL_OUTPUTS = C_OUT_DIM * C_OUT_DIM;

  // Width able to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv2_adder_tree_sequencer_gate_valid_pipe.sv
// Valid-token shift register for the gated adder tree: one bit per stage plus the
// final output register, and the next-cycle prefix-OR that drives supply gating.
module gate_valid_pipe #(
  parameter int unsigned NUM_STAGES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_in,
  output logic [NUM_STAGES:0]   pipe,
  output logic [NUM_STAGES-1:0] prefix_next_c,
  output logic                  empty_next_c
);

  logic [NUM_STAGES:0] pipe_d;
  logic                run_or;

  always_comb begin
    pipe_d = {pipe[NUM_STAGES-1:0], shift_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= pipe_d;
    end
  end

  // Stage k stays powered while any token sits at or before its input.
  always_comb begin
    prefix_next_c = '0;
    run_or        = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      run_or           = run_or | pipe_d[k];
      prefix_next_c[k] = run_or;
    end
    empty_next_c = (pipe_d == '0);
  end

endmodule

// File: rtl/conv2_adder_tree_sequencer.sv
// Sequences operand and supply gating of the conv layer 2 adder tree: wakes the
// stages, accepts one window per cycle up to the frame size, drains, reports done.
module conv2_adder_tree_sequencer
  import conv2_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = C_NUM_STAGES,
  parameter int unsigned WAKE_CYCLES   = 2,
  parameter int unsigned TOTAL_OUTPUTS = C_TOTAL_OUTPUTS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] supply_en,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned       CNT_W     = cnt_width(TOTAL_OUTPUTS);
  localparam int unsigned       WAKE_W    = 4;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TOTAL_OUTPUTS);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

  seq_state_t                state_q, state_d;
  logic [WAKE_W-1:0]         wake_q, wake_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      in_ready_d;
  logic [NUM_STAGES-1:0]     supply_d;
  logic                      busy_d;
  logic                      done_d;
  logic                      accept_c;
  logic [NUM_STAGES:0]       pipe;
  logic [NUM_STAGES-1:0]     prefix_next_c;
  logic                      empty_next_c;

  assign accept_c  = in_valid & in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign stage_en  = pipe[NUM_STAGES-1:0];
  assign out_valid = pipe[NUM_STAGES];

  gate_valid_pipe #(
    .NUM_STAGES(NUM_STAGES)
  ) u_pipe (
    .clk          (clk),
    .reset        (reset),
    .shift_in     (accept_c),
    .pipe         (pipe),
    .prefix_next_c(prefix_next_c),
    .empty_next_c (empty_next_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wake_q     <= '0;
      cnt_q      <= '0;
      in_ready   <= 1'b0;
      supply_en  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_q     <= wake_d;
      cnt_q      <= cnt_d;
      in_ready   <= in_ready_d;
      supply_en  <= supply_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    wake_d     = wake_q;
    cnt_d      = cnt_q;
    in_ready_d = 1'b0;
    supply_d   = '0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = S_WAKE;
          wake_d   = WAKE_LOAD;
          cnt_d    = '0;
          busy_d   = 1'b1;
          supply_d = '1;
        end
      end
      S_WAKE: begin
        supply_d = '1;
        if (wake_q == '0) begin
          state_d    = S_RUN;
          in_ready_d = 1'b1;
        end else begin
          wake_d = wake_q - WAKE_W'(1);
        end
      end
      S_RUN: begin
        supply_d   = '1;
        in_ready_d = 1'b1;
        if (accept_c) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            state_d    = S_DRAIN;
            in_ready_d = 1'b0;
            supply_d   = prefix_next_c;
          end
        end
      end
      S_DRAIN: begin
        if (empty_next_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          supply_d = prefix_next_c;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_conv2_adder_tree_sequencer.sv
// Three sequencer instances with different frame/wake settings, checked every cycle
// against a timeline model built from start/accept/reset events.
module tb_conv2_adder_tree_sequencer;

  localparam int NS   = 5;
  localparam int NI   = 3;
  localparam int MAXC = 8192;
  localparam int T0 = 4, T1 = 3, T2 = 1;
  localparam int W0 = 2, W1 = 3, W2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst        [NI];
  logic          start      [NI];
  logic          in_valid   [NI];
  logic          in_ready   [NI];
  logic [NS-1:0] stage_en   [NI];
  logic [NS-1:0] supply_en  [NI];
  logic          out_valid  [NI];
  logic          busy       [NI];
  logic          frame_done [NI];

  conv2_adder_tree_sequencer #(.NUM_STAGES(NS), .WAKE_CYCLES(W0), .TOTAL_OUTPUTS(T0)) u0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .stage_en(stage_en[0]), .supply_en(supply_en[0]),
    .out_valid(out_valid[0]), .busy(busy[0]), .frame_done(frame_done[0]));

  conv2_adder_tree_sequencer #(.NUM_STAGES(NS), .WAKE_CYCLES(W1), .TOTAL_OUTPUTS(T1)) u1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .stage_en(stage_en[1]), .supply_en(supply_en[1]),
    .out_valid(out_valid[1]), .busy(busy[1]), .frame_done(frame_done[1]));

  conv2_adder_tree_sequencer #(.NUM_STAGES(NS), .WAKE_CYCLES(W2), .TOTAL_OUTPUTS(T2)) u2 (
    .clk(clk), .reset(rst[2]), .start(start[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .stage_en(stage_en[2]), .supply_en(supply_en[2]),
    .out_valid(out_valid[2]), .busy(busy[2]), .frame_done(frame_done[2]));

  // Model: cycle c is the interval after edge c; events are recorded by edge number.
  int cyc = 0;
  bit active     [NI] = '{0, 0, 0};
  bit seen_reset [NI] = '{0, 0, 0};
  int s_edge     [NI] = '{0, 0, 0};
  int last       [NI] = '{-1, -1, -1};
  int nacc       [NI] = '{0, 0, 0};
  int rst_edge   [NI] = '{-1, -1, -1};
  bit acc        [NI][MAXC];

  int checks   = 0;
  int failures = 0;
  int s_a = -1000;
  int s_b = -1000;

  function automatic int tot_of(input int i);
    return (i == 0) ? T0 : (i == 1) ? T1 : T2;
  endfunction

  function automatic int wake_of(input int i);
    return (i == 0) ? W0 : (i == 1) ? W1 : W2;
  endfunction

  function automatic bit acc_at(input int i, input int e);
    if (e < 0 || e >= MAXC || e <= rst_edge[i]) return 1'b0;
    return acc[i][e];
  endfunction

  function automatic bit m_idle(input int i, input int c);
    return !active[i] || (last[i] >= 0 && c >= last[i] + 3 + NS);
  endfunction

  function automatic bit m_in_ready(input int i, input int c);
    return !m_idle(i, c) && last[i] < 0 && c >= s_edge[i] + 1 + wake_of(i);
  endfunction

  function automatic bit m_done(input int i, input int c);
    return active[i] && last[i] >= 0 && c == last[i] + 2 + NS;
  endfunction

  function automatic logic [NS-1:0] m_stage(input int i, input int c);
    logic [NS-1:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) v[k] = acc_at(i, c - 1 - k);
    return v;
  endfunction

  function automatic logic [NS-1:0] m_supply(input int i, input int c);
    logic [NS-1:0] v;
    logic o;
    v = '0;
    o = 1'b0;
    if (m_idle(i, c) || m_done(i, c)) return '0;
    if (last[i] < 0 || c <= last[i]) return '1;
    for (int k = 0; k < NS; k++) begin
      o    = o | acc_at(i, c - 1 - k);
      v[k] = o;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        active[i]     = 1'b0;
        last[i]       = -1;
        rst_edge[i]   = cyc;
        seen_reset[i] = 1'b1;
      end else if (m_idle(i, cyc)) begin
        if (start[i]) begin
          active[i] = 1'b1;
          s_edge[i] = cyc;
          last[i]   = -1;
          nacc[i]   = 0;
        end
      end else if (m_in_ready(i, cyc) && in_valid[i] && cyc < MAXC) begin
        acc[i][cyc] = 1'b1;
        nacc[i]     = nacc[i] + 1;
        if (nacc[i] == tot_of(i)) last[i] = cyc;
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk1(input string name, input int i, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      if (failures <= 50)
        $display("FAIL %s inst%0d cycle %0d: got %b expected %b", name, i, cyc, act, exp);
    end
  endtask

  task automatic chkv(input string name, input int i, input logic [NS-1:0] act,
                      input logic [NS-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      if (failures <= 50)
        $display("FAIL %s inst%0d cycle %0d: got %b expected %b", name, i, cyc, act, exp);
    end
  endtask

  // Hand-derived expectations for the directed frames (d = cycles after start edge).
  task automatic lit_a(input int d);
    case (d)
      1:  begin chk1("a_busy", 0, busy[0], 1'b1); chkv("a_supply", 0, supply_en[0], 5'b11111);
                chk1("a_ready", 2, in_ready[2], 1'b0); end
      2:  begin chk1("a_ready", 0, in_ready[0], 1'b0); chk1("a_ready", 2, in_ready[2], 1'b1); end
      3:  begin chk1("a_ready", 0, in_ready[0], 1'b1); chk1("a_ready", 1, in_ready[1], 1'b0);
                chk1("a_ready", 2, in_ready[2], 1'b0); end
      4:  begin chk1("a_stage0", 0, stage_en[0][0], 1'b1); chk1("a_ready", 1, in_ready[1], 1'b1); end
      6:  chk1("a_ready", 0, in_ready[0], 1'b1);
      7:  begin chk1("a_ready", 0, in_ready[0], 1'b0); chk1("a_stage0", 0, stage_en[0][0], 1'b1);
                chkv("a_supply", 0, supply_en[0], 5'b11111); chk1("a_outv", 2, out_valid[2], 1'b0);
                chk1("a_stage2", 1, stage_en[1][2], 1'b1); end
      8:  begin chk1("a_stage0", 0, stage_en[0][0], 1'b0); chk1("a_outv", 0, out_valid[0], 1'b0);
                chkv("a_supply", 0, supply_en[0], 5'b11110); chk1("a_outv", 2, out_valid[2], 1'b1);
                chk1("a_stage2", 1, stage_en[1][2], 1'b0); end
      9:  begin chk1("a_outv", 0, out_valid[0], 1'b1); chkv("a_supply", 0, supply_en[0], 5'b11100);
                chk1("a_done", 2, frame_done[2], 1'b1); chk1("a_stage2", 1, stage_en[1][2], 1'b1); end
      10: begin chkv("a_supply", 0, supply_en[0], 5'b11000); chk1("a_outv", 1, out_valid[1], 1'b1);
                chk1("a_busy", 2, busy[2], 1'b0); end
      11: begin chkv("a_supply", 0, supply_en[0], 5'b10000); chk1("a_outv", 1, out_valid[1], 1'b0); end
      12: begin chkv("a_supply", 0, supply_en[0], 5'b00000); chk1("a_outv", 0, out_valid[0], 1'b1);
                chk1("a_outv", 1, out_valid[1], 1'b1); end
      13: begin chk1("a_done", 0, frame_done[0], 1'b1); chk1("a_busy", 0, busy[0], 1'b1);
                chk1("a_outv", 1, out_valid[1], 1'b1); end
      14: begin chk1("a_busy", 0, busy[0], 1'b0); chk1("a_done", 1, frame_done[1], 1'b1); end
      default: ;
    endcase
  endtask

  task automatic lit_b(input int d);
    case (d)
      6:  chkv("b_stage", 0, stage_en[0], 5'b00111);
      7:  begin chk1("b_ready", 0, in_ready[0], 1'b0); chk1("b_busy", 0, busy[0], 1'b0);
                chk1("b_outv", 0, out_valid[0], 1'b0); chk1("b_done", 0, frame_done[0], 1'b0);
                chkv("b_stage", 0, stage_en[0], 5'b00000); chkv("b_supply", 0, supply_en[0], 5'b00000); end
      21: chk1("b_done", 0, frame_done[0], 1'b1);
      22: chk1("b_busy", 0, busy[0], 1'b0);
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (seen_reset[i]) begin
        chk1("in_ready", i, in_ready[i], m_in_ready(i, cyc));
        chkv("stage_en", i, stage_en[i], m_stage(i, cyc));
        chkv("supply_en", i, supply_en[i], m_supply(i, cyc));
        chk1("out_valid", i, out_valid[i], acc_at(i, cyc - 1 - NS));
        chk1("busy", i, busy[i], !m_idle(i, cyc));
        chk1("frame_done", i, frame_done[i], m_done(i, cyc));
      end
    end
    lit_a(cyc - s_a);
    lit_b(cyc - s_b);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; in_valid[i] = 1'b0;
    end
    repeat (3) next_cycle();
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    repeat (2) next_cycle();

    // Back-to-back (inst0), bubbles (inst1), degenerate (inst2); stray start/in_valid.
    s_a = cyc;
    for (int d = 0; d < 26; d++) begin
      start[0]    = (d == 0) || (d == 5);
      start[1]    = (d == 0);
      start[2]    = (d == 0);
      in_valid[0] = 1'b1;
      in_valid[1] = (d != 5);
      in_valid[2] = 1'b1;
      next_cycle();
    end
    for (int i = 0; i < NI; i++) begin start[i] = 1'b0; in_valid[i] = 1'b0; end
    next_cycle();

    // Reset two cycles after the second accept, then a fresh full frame.
    s_b = cyc;
    for (int d = 0; d < 30; d++) begin
      start[0]    = (d == 0) || (d == 8);
      in_valid[0] = 1'b1;
      rst[0]      = (d == 6);
      in_valid[1] = 1'($urandom_range(0, 1));
      in_valid[2] = 1'($urandom_range(0, 1));
      next_cycle();
    end
    start[0] = 1'b0;

    // Randomized traffic with occasional resets and stray starts.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NI; i++) begin
        rst[i]      = ($urandom_range(0, 199) == 0);
        start[i]    = ($urandom_range(0, 5) == 0);
        in_valid[i] = ($urandom_range(0, 3) != 0);
      end
      next_cycle();
    end
    for (int i = 0; i < NI; i++) begin rst[i] = 1'b0; start[i] = 1'b0; in_valid[i] = 1'b0; end
    repeat (20) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
